microprocessor_core: RTL and testbench

- Parametrised single-cycle successor of the team's 8-bit four-register teaching microprocessor.
- Widens the datapath, register file, data memory and PC by parameter, and extends the ISA from 4 to 8 opcodes (SUB, BEQ, ADDI, HALT).
- Executes one instruction per `step` strobe instead of per divided clock. The board top keeps the frequency divider and 7-segment drivers, and feeds this core a step strobe plus the instruction from the switch/ROM source.

---
 rtl/microprocessor_core_if.sv | 35 +++
 rtl/microprocessor_core.sv | 187 ++++++++++++++++++
 tb/tb_microprocessor_core.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/microprocessor_core_if.sv
// Bus between the board top and microprocessor_core: the step strobe, the
// instruction and its address, writeback observation and the debug read port.
interface microprocessor_core_if #(
  parameter int DATA_W   = 8,
  parameter int REG_BITS = 2,
  parameter int PC_W     = 8
) ();
  localparam int INSTR_W = 3 + 3 * REG_BITS;

  logic                step;
  logic [INSTR_W-1:0]  instruction;
  logic [PC_W-1:0]     instruction_address;
  logic [2:0]          op;
  logic                reg_write;
  logic                mem_write;
  logic                mem_read;
  logic [REG_BITS-1:0] rw_num;
  logic [DATA_W-1:0]   rw_data;
  logic                data_invalid;
  logic                halted;
  logic [REG_BITS-1:0] dbg_sel;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    output step, instruction, dbg_sel,
    input  instruction_address, op, reg_write, mem_write, mem_read,
           rw_num, rw_data, data_invalid, halted, dbg_data
  );

  modport slave (
    input  step, instruction, dbg_sel,
    output instruction_address, op, reg_write, mem_write, mem_read,
           rw_num, rw_data, data_invalid, halted, dbg_data
  );
endinterface

// File: rtl/microprocessor_core.sv
// Single-cycle parametrised teaching core: one instruction per step strobe,
// register file and data memory in flops so reset can reinitialise both.
module microprocessor_core #(
  parameter int DATA_W   = 8,
  parameter int REG_BITS = 2,
  parameter int MEM_BITS = 5,
  parameter int PC_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  microprocessor_core_if.slave bus
);
  localparam int INSTR_W   = 3 + 3 * REG_BITS;
  localparam int REG_COUNT = 1 << REG_BITS;
  localparam int DEPTH     = 1 << MEM_BITS;
  localparam int HALF      = DEPTH / 2;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_JUMP  = 3'd3,
    OP_SUB   = 3'd4,
    OP_BEQ   = 3'd5,
    OP_ADDI  = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] mem_q  [DEPTH];
  logic [DATA_W-1:0] mem_init [DEPTH];

  logic [PC_W-1:0]     pc_q, pc_d;
  logic                halted_q, halted_d;
  logic [2:0]          op_q, op_d;
  logic                reg_write_q, reg_write_d;
  logic                mem_write_q, mem_write_d;
  logic                mem_read_q, mem_read_d;
  logic [REG_BITS-1:0] rw_num_q, rw_num_d;
  logic [DATA_W-1:0]   rw_data_q, rw_data_d;
  logic                data_invalid_q, data_invalid_d;

  logic                rf_we;
  logic [REG_BITS-1:0] rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic                mem_we;

  opcode_e             opc;
  logic [REG_BITS-1:0] fa, fb, fc;
  logic [DATA_W-1:0]   imm_data, reg_a, reg_b;
  logic [PC_W-1:0]     imm_pc, pc_inc, branch_target;
  logic [MEM_BITS-1:0] mem_addr;

  // Lower half counts up from 0, upper half counts down from 0 (two's complement).
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem_init
      if (gi < HALF) begin : g_low
        assign mem_init[gi] = DATA_W'(gi);
      end else begin : g_high
        assign mem_init[gi] = DATA_W'(HALF - gi);
      end
    end
  endgenerate

  assign opc      = opcode_e'(bus.instruction[INSTR_W-1 -: 3]);
  assign fa       = bus.instruction[3*REG_BITS-1 -: REG_BITS];
  assign fb       = bus.instruction[2*REG_BITS-1 -: REG_BITS];
  assign fc       = bus.instruction[REG_BITS-1:0];
  assign imm_data = {{(DATA_W-REG_BITS){fc[REG_BITS-1]}}, fc};
  assign imm_pc   = {{(PC_W-REG_BITS){fc[REG_BITS-1]}}, fc};
  assign reg_a    = regs_q[fa];
  assign reg_b    = regs_q[fb];
  assign mem_addr = MEM_BITS'(reg_a + imm_data);
  assign pc_inc        = pc_q + PC_W'(1);
  assign branch_target = pc_inc + imm_pc;

  always_comb begin
    pc_d           = pc_q;
    halted_d       = halted_q;
    op_d           = op_q;
    reg_write_d    = 1'b0;
    mem_write_d    = 1'b0;
    mem_read_d     = 1'b0;
    rw_num_d       = rw_num_q;
    rw_data_d      = rw_data_q;
    data_invalid_d = data_invalid_q;
    rf_we          = 1'b0;
    rf_waddr       = fc;
    rf_wdata       = '0;
    mem_we         = 1'b0;

    if (bus.step && !halted_q) begin
      op_d           = opc;
      pc_d           = pc_inc;
      data_invalid_d = 1'b1;
      case (opc)
        OP_ADD: begin
          rf_we    = 1'b1;
          rf_waddr = fc;
          rf_wdata = reg_a + reg_b;
        end
        OP_LOAD: begin
          rf_we      = 1'b1;
          rf_waddr   = fb;
          rf_wdata   = mem_q[mem_addr];
          mem_read_d = 1'b1;
        end
        OP_STORE: begin
          mem_we      = 1'b1;
          mem_write_d = 1'b1;
        end
        OP_JUMP: pc_d = branch_target;
        OP_SUB: begin
          rf_we    = 1'b1;
          rf_waddr = fc;
          rf_wdata = reg_a - reg_b;
        end
        OP_BEQ: begin
          if (reg_a == reg_b) pc_d = branch_target;
        end
        OP_ADDI: begin
          rf_we    = 1'b1;
          rf_waddr = fb;
          rf_wdata = reg_a + imm_data;
        end
        OP_HALT: begin
          halted_d = 1'b1;
          pc_d     = pc_q;
        end
        default: ;
      endcase
      // Observation outputs track only instructions that write a register.
      if (rf_we) begin
        reg_write_d    = 1'b1;
        rw_num_d       = rf_waddr;
        rw_data_d      = rf_wdata;
        data_invalid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q           <= '0;
      halted_q       <= 1'b0;
      op_q           <= '0;
      reg_write_q    <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      rw_num_q       <= '0;
      rw_data_q      <= '0;
      data_invalid_q <= 1'b1;
    end else begin
      pc_q           <= pc_d;
      halted_q       <= halted_d;
      op_q           <= op_d;
      reg_write_q    <= reg_write_d;
      mem_write_q    <= mem_write_d;
      mem_read_q     <= mem_read_d;
      rw_num_q       <= rw_num_d;
      rw_data_q      <= rw_data_d;
      data_invalid_q <= data_invalid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_init[i];
    end else begin
      if (rf_we) regs_q[rf_waddr] <= rf_wdata;
      if (mem_we) mem_q[mem_addr] <= reg_b;
    end
  end

  assign bus.instruction_address = pc_q;
  assign bus.op                  = op_q;
  assign bus.reg_write           = reg_write_q;
  assign bus.mem_write           = mem_write_q;
  assign bus.mem_read            = mem_read_q;
  assign bus.rw_num              = rw_num_q;
  assign bus.rw_data             = rw_data_q;
  assign bus.data_invalid        = data_invalid_q;
  assign bus.halted              = halted_q;
  assign bus.dbg_data            = regs_q[bus.dbg_sel];
endmodule

// File: tb/tb_microprocessor_core.sv
// Directed table-driven bench for microprocessor_core at default parameters,
// with a hand-written pc wrap-around sequence at the end.
module tb_microprocessor_core;
  localparam logic [2:0] ADD = 3'd0, LOAD = 3'd1, STORE = 3'd2, JUMP = 3'd3;
  localparam logic [2:0] SUB = 3'd4, BEQ = 3'd5, ADDI = 3'd6, HALT = 3'd7;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  microprocessor_core_if bus ();

  microprocessor_core dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rst;
    logic       stp;
    logic [8:0] ins;
    logic [1:0] dsel;
    logic [7:0] pc;
    logic [2:0] op;
    logic       rw;
    logic       mw;
    logic       mr;
    logic [1:0] rn;
    logic [7:0] rd;
    logic       di;
    logic       h;
    logic [7:0] dbg;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [8:0] enc(input logic [2:0] o, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] c);
    return {o, a, b, c};
  endfunction

  task automatic add(input string nm, input logic rst, input logic stp,
                     input logic [8:0] ins, input logic [1:0] dsel,
                     input logic [7:0] pc, input logic [2:0] op,
                     input logic rw, input logic mw, input logic mr,
                     input logic [1:0] rn, input logic [7:0] rd,
                     input logic di, input logic h, input logic [7:0] dbg);
    vec_t v;
    v.name = nm; v.rst = rst; v.stp = stp; v.ins = ins; v.dsel = dsel;
    v.pc = pc; v.op = op; v.rw = rw; v.mw = mw; v.mr = mr;
    v.rn = rn; v.rd = rd; v.di = di; v.h = h; v.dbg = dbg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [step %0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.step = 1'b0;
    bus.instruction = '0;
    bus.dbg_sel = '0;

    //   name            rst   stp   instruction                   dsel   pc     op    rw    mw    mr    rn     rd      di    h     dbg
    add("reset",        1'b1, 1'b0, enc(ADD,  2'd0,2'd0,2'd0), 2'd0, 8'd0,  ADD,  1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    add("load_r1",      1'b0, 1'b1, enc(LOAD, 2'd0,2'd1,2'd1), 2'd1, 8'd1,  LOAD, 1'b1, 1'b0, 1'b1, 2'd1, 8'h01, 1'b0, 1'b0, 8'h01);
    add("add_r2",       1'b0, 1'b1, enc(ADD,  2'd1,2'd1,2'd2), 2'd2, 8'd2,  ADD,  1'b1, 1'b0, 1'b0, 2'd2, 8'h02, 1'b0, 1'b0, 8'h02);
    add("load_wrap31",  1'b0, 1'b1, enc(LOAD, 2'd0,2'd3,2'd3), 2'd3, 8'd3,  LOAD, 1'b1, 1'b0, 1'b1, 2'd3, 8'hF1, 1'b0, 1'b0, 8'hF1);
    add("add_r3_wrap",  1'b0, 1'b1, enc(ADD,  2'd3,2'd3,2'd3), 2'd3, 8'd4,  ADD,  1'b1, 1'b0, 1'b0, 2'd3, 8'hE2, 1'b0, 1'b0, 8'hE2);
    add("addi_r1",      1'b0, 1'b1, enc(ADDI, 2'd0,2'd1,2'd1), 2'd1, 8'd5,  ADDI, 1'b1, 1'b0, 1'b0, 2'd1, 8'h01, 1'b0, 1'b0, 8'h01);
    add("store_m1",     1'b0, 1'b1, enc(STORE,2'd1,2'd1,2'd0), 2'd1, 8'd6,  STORE,1'b0, 1'b1, 1'b0, 2'd1, 8'h01, 1'b1, 1'b0, 8'h01);
    add("sub_r2",       1'b0, 1'b1, enc(SUB,  2'd0,2'd1,2'd2), 2'd2, 8'd7,  SUB,  1'b1, 1'b0, 1'b0, 2'd2, 8'hFF, 1'b0, 1'b0, 8'hFF);
    add("store_m30",    1'b0, 1'b1, enc(STORE,2'd0,2'd2,2'd2), 2'd2, 8'd8,  STORE,1'b0, 1'b1, 1'b0, 2'd2, 8'hFF, 1'b1, 1'b0, 8'hFF);
    add("load_m30",     1'b0, 1'b1, enc(LOAD, 2'd0,2'd3,2'd2), 2'd3, 8'd9,  LOAD, 1'b1, 1'b0, 1'b1, 2'd3, 8'hFF, 1'b0, 1'b0, 8'hFF);
    add("jump_back",    1'b0, 1'b1, enc(JUMP, 2'd0,2'd0,2'd2), 2'd3, 8'd8,  JUMP, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF, 1'b1, 1'b0, 8'hFF);
    add("beq_taken",    1'b0, 1'b1, enc(BEQ,  2'd0,2'd0,2'd1), 2'd3, 8'd10, BEQ,  1'b0, 1'b0, 1'b0, 2'd3, 8'hFF, 1'b1, 1'b0, 8'hFF);
    add("beq_not",      1'b0, 1'b1, enc(BEQ,  2'd0,2'd1,2'd1), 2'd3, 8'd11, BEQ,  1'b0, 1'b0, 1'b0, 2'd3, 8'hFF, 1'b1, 1'b0, 8'hFF);
    for (int k = 0; k < 5; k++)
      add("idle",       1'b0, 1'b0, enc(ADD,  2'd1,2'd1,2'd0), 2'd0, 8'd11, BEQ,  1'b0, 1'b0, 1'b0, 2'd3, 8'hFF, 1'b1, 1'b0, 8'h00);
    add("halt",         1'b0, 1'b1, enc(HALT, 2'd0,2'd0,2'd0), 2'd3, 8'd11, HALT, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF, 1'b1, 1'b1, 8'hFF);
    for (int k = 0; k < 3; k++)
      add("halted_step",1'b0, 1'b1, enc(ADD,  2'd1,2'd1,2'd0), 2'd0, 8'd11, HALT, 1'b0, 1'b0, 1'b0, 2'd3, 8'hFF, 1'b1, 1'b1, 8'h00);
    add("reset_wins",   1'b1, 1'b1, enc(ADD,  2'd1,2'd1,2'd0), 2'd1, 8'd0,  ADD,  1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 8'h00);
    add("load_reinit30",1'b0, 1'b1, enc(LOAD, 2'd0,2'd3,2'd2), 2'd3, 8'd1,  LOAD, 1'b1, 1'b0, 1'b1, 2'd3, 8'hF2, 1'b0, 1'b0, 8'hF2);
    add("load_reinit31",1'b0, 1'b1, enc(LOAD, 2'd0,2'd2,2'd3), 2'd2, 8'd2,  LOAD, 1'b1, 1'b0, 1'b1, 2'd2, 8'hF1, 1'b0, 1'b0, 8'hF1);

    repeat (2) @(posedge clock);
    #1;

    foreach (vecs[i]) begin
      reset           = vecs[i].rst;
      bus.step        = vecs[i].stp;
      bus.instruction = vecs[i].ins;
      bus.dbg_sel     = vecs[i].dsel;
      @(posedge clock);
      #1;
      $display("step %0d %s: pc=%0h op=%0d rw=%0b mw=%0b mr=%0b rn=%0d rd=%0h di=%0b h=%0b dbg=%0h",
               i, vecs[i].name, bus.instruction_address, bus.op, bus.reg_write,
               bus.mem_write, bus.mem_read, bus.rw_num, bus.rw_data,
               bus.data_invalid, bus.halted, bus.dbg_data);
      chk({vecs[i].name, ".pc"},  i, 32'(bus.instruction_address), 32'(vecs[i].pc));
      chk({vecs[i].name, ".op"},  i, 32'(bus.op),           32'(vecs[i].op));
      chk({vecs[i].name, ".rw"},  i, 32'(bus.reg_write),    32'(vecs[i].rw));
      chk({vecs[i].name, ".mw"},  i, 32'(bus.mem_write),    32'(vecs[i].mw));
      chk({vecs[i].name, ".mr"},  i, 32'(bus.mem_read),     32'(vecs[i].mr));
      chk({vecs[i].name, ".rn"},  i, 32'(bus.rw_num),       32'(vecs[i].rn));
      chk({vecs[i].name, ".rd"},  i, 32'(bus.rw_data),      32'(vecs[i].rd));
      chk({vecs[i].name, ".di"},  i, 32'(bus.data_invalid), 32'(vecs[i].di));
      chk({vecs[i].name, ".h"},   i, 32'(bus.halted),       32'(vecs[i].h));
      chk({vecs[i].name, ".dbg"}, i, 32'(bus.dbg_data),     32'(vecs[i].dbg));
    end

    // pc wrap: 256 ADD r0=r0+r0 steps from reset take pc 0 -> 255 -> 0.
    reset    = 1'b1;
    bus.step = 1'b0;
    @(posedge clock);
    #1;
    reset           = 1'b0;
    bus.step        = 1'b1;
    bus.instruction = enc(ADD, 2'd0, 2'd0, 2'd0);
    bus.dbg_sel     = 2'd0;
    for (int n = 1; n <= 256; n++) begin
      @(posedge clock);
      #1;
      chk("wrap.pc", n, 32'(bus.instruction_address), 32'(n % 256));
      chk("wrap.rw", n, 32'(bus.reg_write), 32'd1);
      if (n >= 255)
        $display("wrap step %0d: pc=%0h rw=%0b", n, bus.instruction_address, bus.reg_write);
    end
    bus.step = 1'b0;
    @(posedge clock);
    #1;
    $display("wrap idle: pc=%0h rw=%0b", bus.instruction_address, bus.reg_write);
    chk("wrap_idle.pc", 0, 32'(bus.instruction_address), 32'd0);
    chk("wrap_idle.rw", 0, 32'(bus.reg_write), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
